// File: rtl/cms_ctrl_regfile.sv
// Control/status register file and trace-gating FSM for the continuous monitoring system.
// Host register access, start/end triggers, monitored PC ranges, WFI halt, counter and timestamp.
module cms_ctrl_regfile #(
  parameter int unsigned XLEN              = 64,
  parameter int unsigned CTRL_ADDR_WIDTH   = 8,
  parameter int unsigned CTRL_DATA_WIDTH   = 64,
  parameter int unsigned NUM_RANGES        = 4,
  parameter int unsigned CLK_COUNTER_WIDTH = 64,
  parameter logic [31:0] WFI_INSTRUCTION   = 32'h10500073
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_wr_en,
  input  logic                         ctrl_rd_en,
  input  logic [CTRL_ADDR_WIDTH-1:0]   ctrl_addr,
  input  logic [CTRL_DATA_WIDTH-1:0]   ctrl_wdata,
  output logic [CTRL_DATA_WIDTH-1:0]   ctrl_rdata,
  output logic                         ctrl_rvalid,
  input  logic                         pc_valid,
  input  logic [XLEN-1:0]              pc,
  input  logic [31:0]                  instr,
  output logic                         trace_active,
  output logic                         pc_in_range,
  output logic                         wfi_stopped,
  output logic [CLK_COUNTER_WIDTH-1:0] clk_counter
);

  typedef enum logic [1:0] {IDLE, TRACING, HALTED} state_t;

  state_t                       state, next_state;
  logic                         start_en, end_en;
  logic [XLEN-1:0]              start_addr, end_addr;
  logic [CLK_COUNTER_WIDTH-1:0] last_ts;
  logic [NUM_RANGES-1:0]        lower_en, upper_en;
  logic [XLEN-1:0]              lower [NUM_RANGES];
  logic [XLEN-1:0]              upper [NUM_RANGES];
  logic [CTRL_DATA_WIDTH-1:0]   rd_mux;
  logic                         any_hit;
  logic                         release_wr;

  assign release_wr = ctrl_wr_en && (ctrl_addr == CTRL_ADDR_WIDTH'(4)) && !ctrl_wdata[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      start_en    <= 1'b0;
      end_en      <= 1'b0;
      start_addr  <= '0;
      end_addr    <= '0;
      last_ts     <= '0;
      clk_counter <= '0;
      lower_en    <= '0;
      upper_en    <= '0;
      for (int unsigned k = 0; k < NUM_RANGES; k++) begin
        lower[k] <= '0;
        upper[k] <= '0;
      end
    end else begin
      clk_counter <= clk_counter + CLK_COUNTER_WIDTH'(1);
      if (ctrl_wr_en) begin
        last_ts <= clk_counter;
        case (ctrl_addr)
          CTRL_ADDR_WIDTH'(0): start_en    <= ctrl_wdata[0];
          CTRL_ADDR_WIDTH'(1): end_en      <= ctrl_wdata[0];
          CTRL_ADDR_WIDTH'(2): start_addr  <= ctrl_wdata[XLEN-1:0];
          CTRL_ADDR_WIDTH'(3): end_addr    <= ctrl_wdata[XLEN-1:0];
          CTRL_ADDR_WIDTH'(5): clk_counter <= ctrl_wdata[CLK_COUNTER_WIDTH-1:0];
          default: ;
        endcase
        for (int unsigned k = 0; k < NUM_RANGES; k++) begin
          if (ctrl_addr == CTRL_ADDR_WIDTH'(8 + 4*k)) lower_en[k] <= ctrl_wdata[0];
          if (ctrl_addr == CTRL_ADDR_WIDTH'(9 + 4*k)) upper_en[k] <= ctrl_wdata[0];
          if (ctrl_addr == CTRL_ADDR_WIDTH'(10 + 4*k)) lower[k] <= ctrl_wdata[XLEN-1:0];
          if (ctrl_addr == CTRL_ADDR_WIDTH'(11 + 4*k)) upper[k] <= ctrl_wdata[XLEN-1:0];
        end
      end
    end
  end

  // Read mux sees pre-write register values, so same-cycle read+write returns the old data.
  always_comb begin
    rd_mux = '0;
    case (ctrl_addr)
      CTRL_ADDR_WIDTH'(0): rd_mux[0] = start_en;
      CTRL_ADDR_WIDTH'(1): rd_mux[0] = end_en;
      CTRL_ADDR_WIDTH'(2): rd_mux[XLEN-1:0] = start_addr;
      CTRL_ADDR_WIDTH'(3): rd_mux[XLEN-1:0] = end_addr;
      CTRL_ADDR_WIDTH'(4): rd_mux[0] = wfi_stopped;
      CTRL_ADDR_WIDTH'(5): rd_mux[CLK_COUNTER_WIDTH-1:0] = clk_counter;
      CTRL_ADDR_WIDTH'(6): rd_mux[CLK_COUNTER_WIDTH-1:0] = last_ts;
      default: ;
    endcase
    for (int unsigned k = 0; k < NUM_RANGES; k++) begin
      if (ctrl_addr == CTRL_ADDR_WIDTH'(8 + 4*k))  rd_mux[0] = lower_en[k];
      if (ctrl_addr == CTRL_ADDR_WIDTH'(9 + 4*k))  rd_mux[0] = upper_en[k];
      if (ctrl_addr == CTRL_ADDR_WIDTH'(10 + 4*k)) rd_mux[XLEN-1:0] = lower[k];
      if (ctrl_addr == CTRL_ADDR_WIDTH'(11 + 4*k)) rd_mux[XLEN-1:0] = upper[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_rdata  <= '0;
      ctrl_rvalid <= 1'b0;
    end else begin
      ctrl_rvalid <= ctrl_rd_en;
      if (ctrl_rd_en) ctrl_rdata <= rd_mux;
    end
  end

  always_comb begin
    any_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_RANGES; k++) begin
      if ((lower_en[k] || upper_en[k]) &&
          (!lower_en[k] || (pc >= lower[k])) &&
          (!upper_en[k] || (pc <= upper[k])))
        any_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           pc_in_range <= 1'b0;
    else if (pc_valid) pc_in_range <= any_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // WFI beat outranks every other transition, including a same-cycle release write.
  always_comb begin
    next_state = state;
    if (pc_valid && (instr == WFI_INSTRUCTION)) begin
      next_state = HALTED;
    end else begin
      case (state)
        IDLE:    if (pc_valid && (!start_en || (pc == start_addr))) next_state = TRACING;
        TRACING: if (pc_valid && end_en && (pc == end_addr))        next_state = IDLE;
        HALTED:  if (release_wr)                                    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    trace_active = (state == TRACING);
    wfi_stopped  = (state == HALTED);
  end

endmodule
